axi_conv_sync_fifo: RTL and testbench
=====================================

Name: axi_conv_sync_fifo

Overview:
- Single-clock FIFO that buffers one AXI channel's payload (address/data/response beats) inside the AXI4 convertor path.
- Sits directly upstream of the holding-register controller.
- Its empty and rd_en signals pair with the controller's src_data_valid (= !empty) and get_next_data_src (= rd_en).
- Read data is registered: it appears the cycle after rd_en, in step with the controller's hold_data_valid update, so the holding register gives a zero-bubble, registered output.

Parameters:
- DATA_WIDTH, 64, width of one stored beat.
- ADDR_WIDTH, 4, log2 of depth; depth = 2**ADDR_WIDTH (16).
- AF_THRESH, 12, almost_full asserts when count >= AF_THRESH; legal range 1..depth.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  write request from the producing channel.
- wr_data  input  DATA_WIDTH  beat to store.
- full  output  1  no free entry.
- almost_full  output  1  count >= AF_THRESH; used by the producer for early ready deassertion.
- rd_en  input  1  read request; driven by get_next_data_src.
- rd_data  output  DATA_WIDTH  registered read data, valid the cycle after an accepted read.
- empty  output  1  no stored entry; inverted to form src_data_valid.
- count  output  ADDR_WIDTH+1  number of stored entries, 0..depth.

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
  - Reset values: wr_ptr = 0, rd_ptr = 0, rd_data = 0, empty = 1, full = 0, almost_full = 0, count = 0.
  - Memory contents are not reset.
- Pointers are ADDR_WIDTH+1 bits. The low ADDR_WIDTH bits index the memory; the MSB is the wrap bit.
  - Both pointers increment modulo 2**(ADDR_WIDTH+1), so pointer wrap is natural.
- Flags are decoded combinationally from the registered pointers only. There is no combinational path from wr_en/rd_en to any output.
  - empty = (wr_ptr == rd_ptr).
  - full = (MSBs differ) and (low bits equal).
  - count = wr_ptr - rd_ptr, modulo 2**(ADDR_WIDTH+1).
- Accepted write: wr_en & !full.
  - mem[wr_ptr low bits] <= wr_data; wr_ptr increments.
  - A write while full is dropped; no state change.
- Accepted read: rd_en & !empty.
  - rd_data <= mem[rd_ptr low bits]; rd_ptr increments.
  - A read while empty is ignored; rd_data holds its previous value.
  - rd_data holds its value between accepted reads. This is required because the holding register treats rd_data as its contents until the next accepted read.
- Read latency is 1 cycle.
  - Write-to-empty-deassert latency is 1 cycle.
  - There is no write-to-read bypass: a beat written at edge N can be read at edge N+1 at earliest and appears on rd_data after edge N+1.
- Simultaneous write and read:
  - Not full and not empty: both occur; count is unchanged.
  - When full: the read is accepted and the write is dropped, because full is evaluated on the pre-edge pointers. The producer must not assert wr_en while full.
  - When empty: the write is accepted and the read is ignored.
- Reset mid-operation: all pointers clear immediately (asynchronously). Stored beats are discarded, and empty asserts without waiting for a clock edge.
- Protocol assertions (verification only):
  - No wr_en while full.
  - No rd_en while empty.
  - count never exceeds depth.

Decomposition:
- Shared convertor package holds:
  - the pointer-width helper function (ADDR_WIDTH+1);
  - default DATA_WIDTH constants per AXI channel (AW/AR, W, R, B).
- One natural sub-module, axi_conv_fifo_ram: a simple dual-port RAM with a synchronous write port and a registered read port with read enable.
  - It is inferable as block RAM or LSRAM.
  - The top level keeps pointers, flags and count.

Test Plan:
- Reset then idle: after rst, empty=1, full=0, count=0, rd_data=0. Pulse rd_en for 3 cycles -> rd_ptr, rd_data and empty all unchanged.
- Fill and flags: write 0x10..0x1F on 16 consecutive cycles:
  - almost_full rises the cycle after the 12th write (count=12);
  - full=1 and count=16 after the 16th write;
  - a 17th write of 0xFF is dropped and count stays 16.
- Drain order and latency: from full, hold rd_en for 16 cycles -> rd_data shows 0x10..0x1F one per cycle, each one cycle after its rd_en edge. empty=1 after the last read; rd_data then holds 0x1F.
- Wrap and simultaneous access: preload 5 beats, then run wr_en and rd_en together for 40 cycles with an incrementing pattern -> count stays 5, output order is preserved across pointer wrap, and no data is lost or duplicated.
- Full and empty corner cases:
  - at full, assert wr_en & rd_en -> count goes to 15 and the write data is absent from the later drain;
  - at empty, assert both -> count goes to 1 and the next read returns the written beat.
- Integration with the holding-register controller: random empty/rd_en gaps with a random downstream get_next_data_hold -> scoreboard matches every beat in order, hold_data_valid never asserts without a preceding accepted read, and full throughput (one beat per cycle) holds when downstream is always ready. Assert rst mid-stream -> both blocks return to empty/invalid immediately.

Source files
------------

// File: rtl/axi_conv_sync_fifo_pkg.sv
// Shared AXI convertor definitions: per-channel payload widths and pointer sizing.
package axi_conv_sync_fifo_pkg;

    localparam int AXI_AX_DATA_WIDTH = 64;
    localparam int AXI_W_DATA_WIDTH  = 64;
    localparam int AXI_R_DATA_WIDTH  = 64;
    localparam int AXI_B_DATA_WIDTH  = 8;

    // One extra bit beyond the memory index carries the wrap state.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/axi_conv_fifo_ram.sv
// Simple dual-port RAM: synchronous write, registered read with read enable.
module axi_conv_fifo_ram
    import axi_conv_sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_r;

    // Write port; storage is deliberately left unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read register holds its value between enabled reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_r <= {DATA_WIDTH{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/axi_conv_sync_fifo.sv
// Single-clock payload FIFO feeding the holding-register controller; flags decode
// from registered pointers only, read data is registered with one-cycle latency.
module axi_conv_sync_fifo
    import axi_conv_sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = AXI_W_DATA_WIDTH,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int                PTR_W       = ptr_width(ADDR_WIDTH);
    localparam logic [PTR_W-1:0]  PTR_ONE     = PTR_W'(1);
    localparam logic [PTR_W-1:0]  AF_THRESH_C = PTR_W'(AF_THRESH);

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] count_s;
    logic             empty_s;
    logic             full_s;
    logic             wr_accept_s;
    logic             rd_accept_s;

    // Flags depend only on the pointers, never on the current requests.
    always_comb begin
        count_s = wr_ptr_r - rd_ptr_r;
        empty_s = (wr_ptr_r == rd_ptr_r);
        if ((wr_ptr_r[PTR_W-1] != rd_ptr_r[PTR_W-1]) &&
            (wr_ptr_r[PTR_W-2:0] == rd_ptr_r[PTR_W-2:0])) begin
            full_s = 1'b1;
        end else begin
            full_s = 1'b0;
        end
    end

    assign wr_accept_s = wr_en & ~full_s;
    assign rd_accept_s = rd_en & ~empty_s;

    // Pointer advance on accepted transfers; reset clears them without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (wr_accept_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (rd_accept_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    axi_conv_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_accept_s),
        .wr_addr (wr_ptr_r[PTR_W-2:0]),
        .wr_data (wr_data),
        .rd_en   (rd_accept_s),
        .rd_addr (rd_ptr_r[PTR_W-2:0]),
        .rd_data (rd_data)
    );

    assign empty       = empty_s;
    assign full        = full_s;
    assign count       = count_s;
    assign almost_full = (count_s >= AF_THRESH_C);

endmodule

// File: tb/tb_axi_conv_sync_fifo.sv
// Directed bench for axi_conv_sync_fifo with hand-computed expectations and a
// small in-order scoreboard for the randomized consumer section.
module tb_axi_conv_sync_fifo;

    localparam int DW = 64;
    localparam int AW = 4;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          full;
    logic          almost_full;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          empty;
    logic [AW:0]   count;

    int            total;
    int            bad;
    logic [DW-1:0] sb_q[$];
    logic [DW-1:0] exp_rd;
    logic          hold_valid;
    logic          wr_go;
    logic          rd_go;
    int            ready_pct;

    axi_conv_sync_fifo #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .AF_THRESH  (12)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .almost_full (almost_full),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .empty       (empty),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        wr_data = '0;
        hold_valid = 1'b0;
        #12;
        chk("rst_empty", {63'd0, empty}, 64'd1);
        chk("rst_full", {63'd0, full}, 64'd0);
        chk("rst_af", {63'd0, almost_full}, 64'd0);
        chk("rst_count", {59'd0, count}, 64'd0);
        chk("rst_rd_data", rd_data, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reads while empty are ignored
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_rd_data", rd_data, 64'd0);
            chk("idle_empty", {63'd0, empty}, 64'd1);
            chk("idle_count", {59'd0, count}, 64'd0);
        end
        rd_en = 1'b0;

        // Fill with 0x10..0x1F
        wr_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_data = 64'h10 + 64'(i);
            step();
            chk("fill_count", {59'd0, count}, 64'(i + 1));
            chk("fill_af", {63'd0, almost_full}, (i + 1 >= 12) ? 64'd1 : 64'd0);
            chk("fill_full", {63'd0, full}, (i == 15) ? 64'd1 : 64'd0);
        end
        wr_data = 64'hFF;
        step();
        chk("drop_count", {59'd0, count}, 64'd16);
        chk("drop_full", {63'd0, full}, 64'd1);
        wr_en = 1'b0;

        // Drain in order, one beat per cycle
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            chk("drain_data", rd_data, 64'h10 + 64'(i));
            chk("drain_count", {59'd0, count}, 64'(15 - i));
        end
        chk("drain_empty", {63'd0, empty}, 64'd1);
        step();
        chk("drain_hold", rd_data, 64'h1F);
        rd_en = 1'b0;

        // Preload 5, then concurrent write/read across pointer wrap
        wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_data = 64'h100 + 64'(i);
            step();
        end
        chk("pre_count", {59'd0, count}, 64'd5);
        rd_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wr_data = 64'h105 + 64'(i);
            step();
            chk("wrap_data", rd_data, 64'h100 + 64'(i));
            chk("wrap_count", {59'd0, count}, 64'd5);
        end
        wr_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("wrap_tail", rd_data, 64'h128 + 64'(i));
        end
        chk("wrap_empty", {63'd0, empty}, 64'd1);
        rd_en = 1'b0;

        // Simultaneous access at full: read wins, write dropped
        wr_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_data = 64'h200 + 64'(i);
            step();
        end
        chk("cf_full", {63'd0, full}, 64'd1);
        wr_data = 64'hBAD;
        rd_en = 1'b1;
        step();
        chk("cf_count", {59'd0, count}, 64'd15);
        chk("cf_data", rd_data, 64'h200);
        wr_en = 1'b0;
        for (int i = 1; i < 16; i++) begin
            step();
            chk("cf_drain", rd_data, 64'h200 + 64'(i));
        end
        chk("cf_empty", {63'd0, empty}, 64'd1);

        // Simultaneous access at empty: write wins, read ignored
        wr_en = 1'b1;
        wr_data = 64'h300;
        step();
        chk("ce_count", {59'd0, count}, 64'd1);
        chk("ce_hold", rd_data, 64'h20F);
        wr_en = 1'b0;
        step();
        chk("ce_data", rd_data, 64'h300);
        chk("ce_empty", {63'd0, empty}, 64'd1);
        rd_en = 1'b0;

        // Consumer-side integration: random producer, random then always-ready consumer
        for (int c = 0; c < 400; c++) begin
            ready_pct = (c < 300) ? 60 : 100;
            wr_go = ($urandom_range(0, 99) < 70) && (sb_q.size() < 16);
            rd_go = ($urandom_range(0, 99) < ready_pct) && (sb_q.size() > 0);
            wr_en = wr_go;
            rd_en = rd_go;
            wr_data = {$urandom, $urandom};
            if (rd_go) begin
                exp_rd = sb_q.pop_front();
            end else begin
                exp_rd = exp_rd;
            end
            if (wr_go) begin
                sb_q.push_back(wr_data);
            end
            step();
            hold_valid = rd_go;
            if (hold_valid) begin
                chk("sb_data", rd_data, exp_rd);
            end
            chk("sb_count", {59'd0, count}, 64'(sb_q.size()));
            chk("sb_empty", {63'd0, empty}, (sb_q.size() == 0) ? 64'd1 : 64'd0);
        end

        // Mid-stream reset clears state without a clock edge
        wr_en = 1'b1;
        rd_en = 1'b0;
        wr_data = 64'h55;
        step();
        step();
        rst = 1'b1;
        #1;
        chk("mrst_empty", {63'd0, empty}, 64'd1);
        chk("mrst_count", {59'd0, count}, 64'd0);
        chk("mrst_full", {63'd0, full}, 64'd0);
        chk("mrst_rd_data", rd_data, 64'd0);
        wr_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("post_rst_empty", {63'd0, empty}, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
